// File: rtl/ioctl_loader_pkg.sv
// rtl/ioctl_loader_pkg.sv - shared types and constants for the ioctl ROM loader
//
// Purpose : loader FSM states, ROM target encoding, FIFO entry layout,
//           default ioctl_index routing values and an address range helper.
// Ports   : none (package).

package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    TGT_IPL  = 1'b0,
    TGT_FONT = 1'b1
  } target_t;

  typedef struct packed {
    target_t     sel;
    logic [12:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  localparam int         ENTRY_W        = $bits(fifo_entry_t);
  localparam logic [7:0] IPL_INDEX_DEF  = 8'h00;
  localparam logic [7:0] FONT_INDEX_DEF = 8'h01;

  // True when addr fits in an aw-bit ROM, i.e. addr < 2**aw.
  function automatic logic in_range(input logic [24:0] addr, input int aw);
    return (addr >> aw) == 25'd0;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - synchronous FIFO holding decoded ioctl ROM writes
//
// Purpose : DEPTH-entry FIFO with occupancy count; resets to empty.
// Ports   : clk_sys, reset (async, active high)
//           push/din   - write an entry (ignored when full unless popping)
//           pop/dout   - remove head entry; dout is the current head
//           count      - occupancy, $clog2(DEPTH)+1 bits
//           full/empty - occupancy flags

module loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - buffers ioctl downloads into IPL/font ROM writes
//
// Purpose : decodes ioctl byte strobes to the IPL or font ROM, range checks
//           them, queues them in loader_fifo and issues req/ack writes.
//           Optional feature macro: IOCTL_ROM_LOADER_CHECKSUM_EN (adds a
//           16-bit sum of written bytes on port checksum).
// Ports   : clk_sys, reset (async, active high)
//           ioctl_download/index/wr/addr/dout - download stream in
//           ioctl_wait                        - throttle to the source
//           mem_sel/addr/data/req, mem_ack    - ROM write handshake
//           load_done                         - one-cycle completion pulse
//           err_flags                         - sticky [0] overflow, [1] range
//           checksum (optional)               - sum of written bytes

module ioctl_rom_loader
  import ioctl_loader_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         IPL_AW     = 13,
  parameter int         FONT_AW    = 12,
  parameter logic [7:0] IPL_INDEX  = IPL_INDEX_DEF,
  parameter logic [7:0] FONT_INDEX = FONT_INDEX_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_sel,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        load_done,
  output logic [1:0]  err_flags
`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  state_t           state_nx;
  logic             load_entry;

  fifo_entry_t      entry_in;
  fifo_entry_t      head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CW-1:0]    count;
  logic [CW-1:0]    next_count;
  logic             full;
  logic             empty;

  logic             hit;
  logic             strobe;
  logic             push;
  logic             pop;
  logic             set_ovf;
  logic             set_range;

  // ---------------------------------------------------------------- decode
  always_comb begin
    entry_in      = '0;
    hit           = 1'b0;
    entry_in.data = ioctl_dout;
    // in_range guarantees the bits above the ROM width are zero, so the low
    // 13 address bits are the ROM address for either target.
    if (ioctl_index == IPL_INDEX && in_range(ioctl_addr, IPL_AW)) begin
      hit           = 1'b1;
      entry_in.sel  = TGT_IPL;
      entry_in.addr = ioctl_addr[12:0];
    end else if (ioctl_index == FONT_INDEX && in_range(ioctl_addr, FONT_AW)) begin
      hit           = 1'b1;
      entry_in.sel  = TGT_FONT;
      entry_in.addr = ioctl_addr[12:0];
    end
  end

  assign strobe    = (state == LOAD) && ioctl_wr;
  assign pop       = mem_req && mem_ack;
  assign push      = strobe && hit && (!full || pop);
  assign set_ovf   = strobe && hit && full && !pop;
  assign set_range = strobe && !hit;

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (entry_in),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign head = fifo_entry_t'(fifo_dout);

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_entry = 1'b0;
    unique case (state)
      IDLE: begin
        if (ioctl_download) begin
          state_nx   = LOAD;
          load_entry = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) state_nx = DRAIN;
      end
      DRAIN: begin
        if (empty && !mem_req) state_nx = DONE;
      end
      DONE: begin
        // A download that restarted during DRAIN goes straight back to LOAD.
        if (ioctl_download) begin
          state_nx   = LOAD;
          load_entry = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign load_done = (state == DONE);

  // ------------------------------------------------------- memory handshake
  // mem_req rises one cycle after the head is valid and drops for a cycle
  // after each ack, giving one write every two cycles at best.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                  mem_req <= 1'b0;
    else if (pop)               mem_req <= 1'b0;
    else if (!mem_req && !empty) mem_req <= 1'b1;
  end

  // Payload is masked while idle so the outputs read zero after reset.
  assign mem_sel  = mem_req && (head.sel == TGT_FONT);
  assign mem_addr = mem_req ? head.addr : 13'd0;
  assign mem_data = mem_req ? head.data : 8'd0;

  // ------------------------------------------------------------ throttling
  // Raised one slot early so a strobe already in flight still fits.
  assign next_count = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ioctl_wait <= 1'b0;
    else       ioctl_wait <= (next_count >= CW'(FIFO_DEPTH - 1));
  end

  // ---------------------------------------------------------------- errors
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)           err_flags <= 2'b00;
    else if (load_entry) err_flags <= 2'b00;
    else                 err_flags <= err_flags | {set_range, set_ovf};
  end

`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
  // Summed at the ack, so dropped bytes never contribute.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)           checksum <= 16'd0;
    else if (load_entry) checksum <= 16'd0;
    else if (pop)        checksum <= checksum + {8'd0, head.data};
  end
`endif

endmodule

// File: doc/ioctl_rom_loader.md
Name: ioctl_rom_loader

Overview:
- Upstream of the sharpx1 core; sits between the HPS/sim ioctl download stream and the core's IPL/font ROM write ports.
- Buffers ioctl byte writes in a small FIFO, decodes ioctl_index to a target ROM, range-checks addresses and issues req/ack writes.
- Throttles the source with ioctl_wait and signals completion with load_done.

Parameters:
- FIFO_DEPTH, 4, FIFO entries; power of two, >=2.
- IPL_AW, 13, IPL ROM address width (8 KiB).
- FONT_AW, 12, font ROM address width (4 KiB).
- IPL_INDEX, 8'h00, ioctl_index value routed to the IPL ROM.
- FONT_INDEX, 8'h01, ioctl_index value routed to the font ROM.

Ports:
- clk_sys  in  1  system clock (48 MHz in sim).
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download target selector.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address within the image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  source must hold off further strobes.
- mem_sel  out  1  0=IPL, 1=font; valid while mem_req is high.
- mem_addr  out  13  ROM byte address; font uses [11:0], bit 12 is 0.
- mem_data  out  8  ROM write data.
- mem_req  out  1  write request; held until acknowledged.
- mem_ack  in  1  write accepted in this cycle.
- load_done  out  1  one-cycle pulse when a download has fully drained.
- err_flags  out  2  sticky: [0] FIFO overflow, [1] address/index out of range.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; err_flags cleared.
- Asynchronous assertion; deassertion is sampled on clk_sys. Reset mid-download discards FIFO contents and any outstanding request.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE -> LOAD on ioctl_download=1. Entering LOAD clears err_flags.
  - LOAD -> DRAIN on ioctl_download falling.
  - DRAIN -> DONE when the FIFO is empty and no request is outstanding.
  - DONE: load_done=1 for one cycle, then IDLE.
  - If ioctl_download reasserts during DRAIN, finish draining first, pass through DONE, then go to LOAD.
- Accept decode, in LOAD on ioctl_wr:
  - index==IPL_INDEX and addr < 2^IPL_AW: push {sel=0, addr, data}.
  - index==FONT_INDEX and addr < 2^FONT_AW: push {sel=1, addr, data}.
  - Any other index or an out-of-range address: byte dropped, err_flags[1] set.
  - FIFO full at the strobe: byte dropped, err_flags[0] set.
  - ioctl_wr outside LOAD: ignored, no error.
- ioctl_wait: registered; high when occupancy >= FIFO_DEPTH-1 after this cycle's push/pop. This leaves one slot for a strobe that is already in flight.
- Memory handshake:
  - The FIFO head drives mem_sel/addr/data. mem_req rises the cycle after the head becomes valid.
  - mem_req and the payload stay stable until the cycle mem_ack=1 is sampled; the pop happens that cycle and mem_req drops for at least one cycle.
  - Sustained throughput: one write per 2 cycles.
  - mem_ack without mem_req is ignored.
- Simultaneous push and pop: occupancy unchanged; the push is legal even when full-at-start, because the pop frees a slot in the same cycle.
- Pointers wrap modulo FIFO_DEPTH; occupancy is held in a log2(FIFO_DEPTH)+1-bit counter.
- Latency: a strobe into an empty FIFO gives mem_req high 2 cycles later.

Optional Feature:
- Macro: IOCTL_ROM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum[15:0]: a 16-bit modular sum of every byte actually written, counted at mem_ack.
  - Cleared on entering LOAD; stable from DONE until the next LOAD.
- When undefined: the port is absent and no adder is inferred.

Decomposition:
- Package ioctl_loader_pkg:
  - State enum {IDLE, LOAD, DRAIN, DONE}.
  - Target enum {TGT_IPL=0, TGT_FONT=1}.
  - FIFO entry struct {sel, addr[12:0], data[7:0]}.
  - Index constants.
- Sub-module: loader_fifo, a synchronous FIFO with count, full and empty outputs, reset to empty. This is the single natural split.

Test Plan:
- Write 16 bytes, index 0, addr 0..15, data = addr^8'hA5, mem_ack tied high → 16 IPL writes in order with matching data; err_flags=0; load_done pulses once after ioctl_download falls.
- Font load, index 1, addr 4095 then addr 4096 → one font write at 12'hFFF; err_flags[1]=1; 4096 is dropped.
- mem_ack held low, strobes every cycle → ioctl_wait high once occupancy reaches 3. A 5th strobe sent regardless is dropped with err_flags[0]=1; after ack resumes, exactly 4 writes come out.
- Index 8'h05 bytes → no mem_req; err_flags[1]=1.
- Reset asserted with 2 entries queued and mem_req high → all outputs 0 asynchronously; no further writes after release.
- With IOCTL_ROM_LOADER_CHECKSUM_EN: bytes 8'hFF, 8'h02, 8'h10 → checksum=16'h0111 at load_done.
